// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the round-robin counter scheduler.
// Holds the FSM state enum, default sizing, and a one-hot helper.
package counter_sched_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 3;
    localparam int MAXREQ   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Callers size-cast the result down to their own requester count.
    function automatic logic [MAXREQ-1:0] onehot(input logic [4:0] idx);
        onehot = {{(MAXREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping.
// Ports: req (requests), ptr (search start), win (one-hot winner, 0 if none).
module counter_sched_rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Time-shares one CW-bit up-counter among NREQ requesters, round-robin.
// Ports: clk, reset (sync, active-high), req, len (packed CW per requester),
//   grant (one-hot owner), busy, cnt, done (one-cycle finish pulse),
//   abort (only when COUNTER_SCHED_ABORT_EN is defined).
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
`ifdef COUNTER_SCHED_ABORT_EN
    input  logic               abort,
`endif
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [CW-1:0]      cnt,
    output logic [NREQ-1:0]    done
);

    localparam int PW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   own_q, own_d;

    logic [NREQ-1:0] win;
    logic [PW-1:0]   win_idx;
    logic [CW-1:0]   len_sel;
    logic [PW-1:0]   nxt_ptr;
    logic            abort_w;

`ifdef COUNTER_SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    counter_sched_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .win (win)
    );

    // Winner index and its length slice, picked with constant offsets.
    always_comb begin
        win_idx = '0;
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
                len_sel = len[i*CW +: CW];
            end
        end
    end

    assign nxt_ptr = (own_q == PW'(NREQ-1)) ? '0 : own_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = RUN;
                    grant_d = win;
                    cnt_d   = '0;
                    len_d   = len_sel;
                    own_d   = win_idx;
                end
            end
            RUN: begin
                if (abort_w) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = nxt_ptr;
                end else if (cnt_q == len_q) begin
                    state_d = DONE;
                    grant_d = '0;
                    cnt_d   = '0;
                    done_d  = NREQ'(onehot(5'(own_q)));
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = nxt_ptr;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign cnt   = cnt_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: timeline model plus directed scenarios.
// Abort scenario runs only when COUNTER_SCHED_ABORT_EN is defined.
module tb_counter_sched;

    localparam int NREQ = 4;
    localparam int CW   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic               abort = 1'b0;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [CW-1:0]      cnt;
    logic [NREQ-1:0]    done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_sched #(
        .NREQ (NREQ),
        .CW   (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
`ifdef COUNTER_SCHED_ABORT_EN
        .abort (abort),
`endif
        .grant (grant),
        .busy  (busy),
        .cnt   (cnt),
        .done  (done)
    );

    task automatic cmp(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, got, want, $time);
        end
    endtask

    // Timeline model: a grant taken at edge e0 with length L shows
    // cnt=k after edge e0+k (k<=L), done after e0+L+1, idle after e0+L+2.
    int              e = 0;
    int              e0 = 0;
    int              mL = 0;
    int              mown = 0;
    int              mptr = 0;
    int              k;
    bit              act = 0;
    bit              mvalid = 0;
    logic [NREQ-1:0] xg = '0;
    logic [NREQ-1:0] xd = '0;
    logic [CW-1:0]   xc = '0;
    logic            xb = 1'b0;

    always @(posedge clk) begin
        e++;
        xg = '0;
        xd = '0;
        xc = '0;
        xb = 1'b0;
        if (reset) begin
            act    = 0;
            mptr   = 0;
            mvalid = 1;
        end else if (act) begin
            k = e - e0;
            if (abort && k <= mL + 1) begin
                act  = 0;
                mptr = (mown + 1) % NREQ;
            end else if (k <= mL) begin
                xg = NREQ'(1) << mown;
                xc = CW'(k);
                xb = 1'b1;
            end else if (k == mL + 1) begin
                xd   = NREQ'(1) << mown;
                xb   = 1'b1;
                mptr = (mown + 1) % NREQ;
            end else begin
                act = 0;
            end
        end else if (req != '0) begin
            for (int j = NREQ - 1; j >= 0; j--) begin
                if (req[(mptr + j) % NREQ]) mown = (mptr + j) % NREQ;
            end
            e0  = e;
            act = 1;
            mL  = int'(len[mown*CW +: CW]);
            xg  = NREQ'(1) << mown;
            xb  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            cmp("grant", 32'(grant), 32'(xg));
            cmp("done", 32'(done), 32'(xd));
            cmp("cnt", 32'(cnt), 32'(xc));
            cmp("busy", 32'(busy), 32'(xb));
            cmp("grant_done_excl", 32'(|grant && |done), 32'd0);
        end
    end

    int gcnt;
    int dcnt;

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        len   = '0;

        // Reset held with all requests asserted
        repeat (2) begin
            @(negedge clk);
            cmp("rst_grant", 32'(grant), 32'd0);
            cmp("rst_done", 32'(done), 32'd0);
            cmp("rst_cnt", 32'(cnt), 32'd0);
            cmp("rst_busy", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        req   = '0;
        @(negedge clk);

        // Single requester, L=3
        req = 4'b0001;
        len = 12'h003;
        @(negedge clk);
        req = '0;
        for (int j = 0; j < 4; j++) begin
            cmp("t2_grant", 32'(grant), 32'h1);
            cmp("t2_cnt", 32'(cnt), 32'(j));
            @(negedge clk);
        end
        cmp("t2_done", 32'(done), 32'h1);
        cmp("t2_grant_off", 32'(grant), 32'h0);
        @(negedge clk);
        cmp("t2_idle", 32'(busy), 32'h0);

        // All requesting, L=0 everywhere: rotation from ptr=0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1111;
        len   = '0;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            cmp("t3_grant", 32'(grant), 32'(1 << (g % 4)));
            @(negedge clk);
            cmp("t3_done", 32'(done), 32'(1 << (g % 4)));
            @(negedge clk);
            @(negedge clk);
        end
        req = '0;
        repeat (4) @(negedge clk);

        // Length and request changed mid-run are ignored
        req = 4'b0001;
        len = 12'h002;
        @(negedge clk);
        cmp("t4_grant", 32'(grant), 32'h1);
        len  = 12'h007;
        req  = '0;
        gcnt = 1;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (grant != '0) gcnt++;
            if (done == 4'b0001) dcnt++;
        end
        cmp("t4_run_len", 32'(gcnt), 32'd3);
        cmp("t4_done_cnt", 32'(dcnt), 32'd1);

        // Reset in the middle of a run
        req = 4'b0010;
        len = 12'h028;
        @(negedge clk);
        cmp("t5_grant", 32'(grant), 32'h2);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        cmp("t5_cnt2", 32'(cnt), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        cmp("t5_rst_grant", 32'(grant), 32'h0);
        cmp("t5_rst_cnt", 32'(cnt), 32'h0);
        cmp("t5_rst_busy", 32'(busy), 32'h0);
        cmp("t5_rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        req   = 4'b0011;
        len   = '0;
        @(negedge clk);
        cmp("t5_regrant", 32'(grant), 32'h1);
        req = '0;
        @(negedge clk);
        cmp("t5_done0", 32'(done), 32'h1);
        repeat (2) @(negedge clk);

`ifdef COUNTER_SCHED_ABORT_EN
        // Abort mid-run
        req = 4'b0100;
        len = 12'h140;
        @(negedge clk);
        cmp("t6_grant", 32'(grant), 32'h4);
        req = '0;
        @(negedge clk);
        cmp("t6_cnt1", 32'(cnt), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        cmp("t6_ab_grant", 32'(grant), 32'h0);
        cmp("t6_ab_busy", 32'(busy), 32'h0);
        cmp("t6_ab_done", 32'(done), 32'h0);
        abort = 1'b0;
        req   = 4'b1111;
        len   = '0;
        @(negedge clk);
        cmp("t6_next", 32'(grant), 32'h8);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
